osc_period_meter: RTL and testbench
===================================

# osc_period_meter

Measures the period and high time of an asynchronous oscillation input, counted in `clk` cycles. It is the receive-side counterpart of the team's digitally controlled oscillators: it recovers the period and duty settings from a running oscillation. It is used for closed-loop calibration of DCO settings and for decoding resonate-and-fire spike trains into numeric intervals. Results come out on a registered bus with a one-cycle `valid` strobe and a `timeout` strobe when no edge arrives.

## Interface
- `W`, default 8: width of the period/high counters and result buses.

- `clk`  input  1  sampling clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `osc`  input  1  oscillation under measurement; asynchronous to `clk`.
- `en`  input  1  measurement enable; level-sensitive.
- `period`  output  W  last valid measurement: rising-edge-to-rising-edge cycles − 1 (same convention as DCO `maxVal`).
- `high`  output  W  last valid measurement: high cycles in that period − 1.
- `valid`  output  1  one-cycle strobe when `period`/`high` update.
- `timeout`  output  1  one-cycle strobe when no rising edge arrives within 2^W cycles.

Clocking and reset: single clock domain (`clk`); `reset` is asynchronous and active-high.

## Operation
- Synchronizer:
  - `osc` passes through a 2-flop synchronizer (`s1`, `s2`), then a history flop `sp`. All three reset to 0.
  - `lvl` = `s2`.
  - `rise` = `s2 & ~sp`.
- FSM states: IDLE, WAIT_LOW, ARM, MEAS. Reset state is IDLE.
  - IDLE: counters cleared. If `en`=1, go to WAIT_LOW.
  - WAIT_LOW: if `lvl`=0, go to ARM. This discards an `osc` that is already high at enable or reset release, so a false first edge is never used.
  - ARM: on `rise`, set `cnt_p`←0 and `cnt_h`←0, then go to MEAS. No `valid` is issued in ARM.
  - MEAS, every cycle without `rise`:
    - `cnt_p`←`cnt_p`+1.
    - `cnt_h`←`cnt_h`+1 if `lvl`=1.
  - MEAS, on `rise`:
    - `period`←`cnt_p` and `high`←`cnt_h`.
    - Pulse `valid`.
    - Reload `cnt_p`←0 and `cnt_h`←0, and stay in MEAS. Measurement is back-to-back with no dead cycles.
  - MEAS, timeout: if `cnt_p` = 2^W−1 and `rise`=0, pulse `timeout`, clear counters and go to WAIT_LOW. `period`/`high` hold their prior values.
  - Any state with `en`=0: go to IDLE next cycle and clear counters. Outputs hold; no `valid` or `timeout` is issued.
- Width rules:
  - `cnt_h` ≤ `cnt_p` always, so `cnt_h` never overflows.
  - Counters never wrap. Reaching 2^W−1 without an edge is the timeout condition.
- Simultaneous events:
  - `rise` in the cycle where `cnt_p` = 2^W−1: the capture wins. `period`=2^W−1, `valid` pulses, no `timeout`.
  - `en` falling in the same cycle as `rise`: `en` wins. No `valid`.
- Reset mid-measurement: all flops clear immediately.

## Timing
- Reset values: `period`=0, `high`=0, `valid`=0, `timeout`=0. `s1`, `s2`, `sp` and all counters are 0.
- Latency: an `osc` rising edge first sampled by `s1` at clk edge k gives `rise` during cycle k+1..k+2. `period`/`high`/`valid` are registered at clk edge k+2.
- `valid` and `timeout` are exactly one cycle wide and never asserted together.
- `period` and `high` change only in the cycle `valid` goes high.
- Resolvable input:
  - Minimum: 1 sampled high cycle + 1 sampled low cycle, which gives `period`=1, `high`=0.
  - Shorter pulses may be missed. This is accepted behaviour.
- Accuracy: ±1 cycle per measurement, due to synchronizer quantization of an asynchronous `osc`. Results are exact for an `osc` generated from `clk`.
- After enable: the first `valid` arrives no earlier than the second observed rising edge, plus 2 cycles.

## Test plan
- `osc` derived from `clk` with period 10 and high 4, `en`=1, W=8 → first measurement discarded; then `period`=9, `high`=3, `valid` every 10 cycles, `timeout` never asserted.
- 1-high/1-low alternating `osc` → `period`=1, `high`=0, `valid` every 2 cycles; then period 256 (`osc` high 1 cycle) → `period`=255, `high`=0, no `timeout`.
- `osc` rises once then stays low, W=8 → `timeout` pulses 256 cycles after the captured rising edge. `period`/`high` keep their previous values. The next two rising edges yield one `valid`.
- `osc` held high through `reset` release with `en`=1 → no `valid` from the false edge. After `osc` falls, rises twice 7 cycles apart with 3 high cycles → `period`=6, `high`=2.
- `en` dropped for 1 cycle mid-period (period 10 stream) → no `valid` for that period, FSM back to IDLE, outputs unchanged. Measurement resumes: WAIT_LOW, then ARM, then `valid` after the second subsequent edge with `period`=9.
- `reset` asserted asynchronously mid-MEAS, between clk edges → all outputs read 0 before the next clk edge. After release, behaviour is identical to a fresh start.

Source files
------------

// File: rtl/osc_period_meter.sv
// rtl/osc_period_meter.sv - measures period and high time of an asynchronous oscillation in clk cycles
module osc_period_meter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         osc,
    input  logic         en,
    output logic [W-1:0] period,
    output logic [W-1:0] high,
    output logic         valid,
    output logic         timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, ARM, MEAS} state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       state;
    logic         s1, s2, sp;
    logic [1:0]   primed;
    logic [W-1:0] cnt_p, cnt_h;
    logic         lvl, rise;

    assign lvl  = s2;
    assign rise = s2 & ~sp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s1      <= 1'b0;
            s2      <= 1'b0;
            sp      <= 1'b0;
            primed  <= 2'b00;
            cnt_p   <= '0;
            cnt_h   <= '0;
            period  <= '0;
            high    <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            s1      <= osc;
            s2      <= s1;
            sp      <= s2;
            // The synchronizer holds stale zeros for two cycles after reset; an osc
            // already high must not be mistaken for low during that window.
            primed  <= {primed[0], 1'b1};
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt_p <= '0;
                cnt_h <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_p <= '0;
                        cnt_h <= '0;
                        state <= WAIT_LOW;
                    end
                    WAIT_LOW: begin
                        if (!lvl && primed[1]) state <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt_p <= '0;
                            cnt_h <= '0;
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            period <= cnt_p;
                            high   <= cnt_h;
                            valid  <= 1'b1;
                            cnt_p  <= '0;
                            cnt_h  <= '0;
                        end else if (cnt_p == CNT_MAX) begin
                            timeout <= 1'b1;
                            cnt_p   <= '0;
                            cnt_h   <= '0;
                            state   <= WAIT_LOW;
                        end else begin
                            cnt_p <= cnt_p + 1'b1;
                            if (lvl) cnt_h <= cnt_h + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osc_period_meter.sv
// tb/tb_osc_period_meter.sv - self-checking bench for osc_period_meter with a pulse-level reference model
module tb_osc_period_meter;

    logic       clk;
    logic       reset;
    logic       osc;
    logic       en;
    logic [7:0] period;
    logic [7:0] high;
    logic       valid;
    logic       timeout;

    osc_period_meter #(.W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .osc     (osc),
        .en      (en),
        .period  (period),
        .high    (high),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int p;
        int h;
    } vexp_t;

    vexp_t vq[$];
    int    tq[$];
    int    cyc;
    int    vectors;
    int    miscompares;
    int    exp_period;
    int    exp_high;
    bit    armed;
    int    last_rise;
    int    last_h;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk cycle: drive osc on the falling edge, check outputs just after the rising edge.
    task automatic tick(input logic o);
        logic ev;
        logic et;
        @(negedge clk);
        osc = o;
        @(posedge clk);
        cyc++;
        #1;
        ev = (vq.size() > 0) && (vq[0].cyc == cyc);
        et = (tq.size() > 0) && (tq[0] == cyc);
        if (ev) begin
            exp_period = vq[0].p;
            exp_high   = vq[0].h;
            void'(vq.pop_front());
        end
        if (et) void'(tq.pop_front());
        check("valid", valid, ev);
        check("timeout", timeout, et);
        check("period", period, exp_period);
        check("high", high, exp_high);
    endtask

    task automatic low(input int n);
        repeat (n) tick(1'b0);
    endtask

    // A rising edge closes the interval opened by the previous armed edge.
    task automatic pulse(input int h, input int l);
        int    c;
        vexp_t e;
        c = cyc + 1;
        if (armed) begin
            e.cyc = c + 2;
            e.p   = c - last_rise - 1;
            e.h   = last_h - 1;
            vq.push_back(e);
        end
        armed     = 1'b1;
        last_rise = c;
        last_h    = h;
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    // No edge for more than 2^W cycles after the last armed edge: one timeout, then re-arm.
    task automatic quiet(input int n);
        if (armed) tq.push_back(last_rise + 258);
        armed = 1'b0;
        low(n);
    endtask

    task automatic drop_en();
        en = 1'b0;
        tick(1'b0);
        en    = 1'b1;
        armed = 1'b0;
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        exp_period  = 0;
        exp_high    = 0;
        armed       = 1'b0;
        last_rise   = 0;
        last_h      = 0;
        reset       = 1'b1;
        en          = 1'b0;
        osc         = 1'b0;
        repeat (3) tick(1'b0);
        reset = 1'b0;
        en    = 1'b1;
        low(6);

        repeat (5) pulse(4, 6);
        repeat (6) pulse(1, 1);
        pulse(1, 255);
        pulse(1, 3);
        quiet(300);
        repeat (3) pulse(2, 5);

        repeat (30) pulse($urandom_range(1, 12), $urandom_range(1, 12));
        repeat (4) pulse($urandom_range(1, 128), $urandom_range(1, 128));

        repeat (3) pulse(4, 6);
        pulse(4, 2);
        drop_en();
        low(3);
        repeat (3) pulse(4, 6);

        #2;
        reset = 1'b1;
        osc   = 1'b1;
        #1;
        check("rst_period", period, 0);
        check("rst_high", high, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        vq.delete();
        tq.delete();
        exp_period = 0;
        exp_high   = 0;
        armed      = 1'b0;
        repeat (3) tick(1'b1);
        reset = 1'b0;
        repeat (5) tick(1'b1);
        low(6);
        pulse(3, 4);
        pulse(3, 4);
        low(5);

        check("pending_valid", vq.size(), 0);
        check("pending_timeout", tq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
